// File: rtl/alert_scheduler.sv
// alert_scheduler: shares one siren among five latched alarm sources.
// Fixed priority, fire preemption, ack/timeout/retry, quiet gap.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   req[4:0]   alarm levels: fire, burglar, shatter, water, rain
//   ack        user acknowledge
//   siren      siren drive, high while announcing
//   alert_code 0 none, 1 rain .. 5 fire
//   busy       high whenever not idle
//   pending    latched events not yet served
//   overrun    sticky: event on an already-pending source
//   unacked    sticky: alert abandoned after all retries

module alert_scheduler #(
  parameter int ANN_CYCLES  = 8,
  parameter int HOLD_CYCLES = 64,
  parameter int GAP_CYCLES  = 4,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] req,
  input  logic       ack,
  output logic       siren,
  output logic [2:0] alert_code,
  output logic       busy,
  output logic [4:0] pending,
  output logic [4:0] overrun,
  output logic [4:0] unacked
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ANN,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [CNT_W-1:0] ANN_END =
    CNT_W'(ANN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_END =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_END =
    CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RETRY_LIM =
    CNT_W'(MAX_RETRY);
  localparam logic [2:0] FIRE = 3'd4;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] retry, retry_n;
  logic [2:0]       cur, cur_n;
  logic [2:0]       gidx;
  logic [2:0]       code_n;
  logic [4:0]       req_q;
  logic [4:0]       rise;
  logic [4:0]       set_m, clr_m;
  logic [4:0]       pend_n, ovr_n, unack_n;

  assign rise = req & ~req_q;

  // highest set pending bit wins
  always_comb begin
    gidx = '0;
    for (int i = 0; i < 5; i++) begin
      if (pending[i]) gidx = 3'(i);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    retry_n = retry;
    cur_n   = cur;
    set_m   = '0;
    clr_m   = '0;
    unack_n = unacked;
    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (|pending) begin
          cur_n   = gidx;
          clr_m   = 5'b00001 << gidx;
          retry_n = '0;
          state_n = S_ANN;
        end
      end
      S_ANN, S_HOLD: begin
        if (ack) begin
          cnt_n   = '0;
          state_n = S_GAP;
        end else if (pending[4] && cur != FIRE) begin
          // park the interrupted source back in the queue
          set_m   = 5'b00001 << cur;
          clr_m   = 5'b10000;
          cur_n   = FIRE;
          retry_n = '0;
          cnt_n   = '0;
          state_n = S_ANN;
        end else if (state == S_ANN) begin
          if (cnt == ANN_END) begin
            cnt_n   = '0;
            state_n = S_HOLD;
          end
        end else if (cnt == HOLD_END) begin
          cnt_n = '0;
          if (retry < RETRY_LIM) begin
            retry_n = retry + CNT_W'(1);
            state_n = S_ANN;
          end else begin
            unack_n = unacked | (5'b00001 << cur);
            state_n = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (cnt == GAP_END) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // a rise always wins over a same-cycle grant clear
  assign pend_n = (pending & ~clr_m) | set_m | rise;
  assign ovr_n  = overrun | (rise & pending & ~clr_m);

  always_comb begin
    code_n = '0;
    if (state_n == S_ANN || state_n == S_HOLD) begin
      code_n = cur_n + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      retry      <= '0;
      cur        <= '0;
      req_q      <= '0;
      pending    <= '0;
      overrun    <= '0;
      unacked    <= '0;
      siren      <= 1'b0;
      alert_code <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      retry      <= retry_n;
      cur        <= cur_n;
      req_q      <= req;
      pending    <= pend_n;
      overrun    <= ovr_n;
      unacked    <= unack_n;
      siren      <= (state_n == S_ANN);
      alert_code <= code_n;
      busy       <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_alert_scheduler.sv
// tb_alert_scheduler: directed stimulus, phase-countdown reference model,
// per-cycle output compare plus hand-computed literal checks.

module tb_alert_scheduler;

  localparam int ANN  = 8;
  localparam int HOLD = 64;
  localparam int GAP  = 4;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] req = '0;
  logic       ack = 1'b0;
  logic       siren;
  logic [2:0] alert_code;
  logic       busy;
  logic [4:0] pending;
  logic [4:0] overrun;
  logic [4:0] unacked;

  int n_cmp = 0;
  int n_bad = 0;

  alert_scheduler #(
    .ANN_CYCLES (ANN),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .MAX_RETRY  (MAXR),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .ack       (ack),
    .siren     (siren),
    .alert_code(alert_code),
    .busy      (busy),
    .pending   (pending),
    .overrun   (overrun),
    .unacked   (unacked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model. Phases: 0 idle, 1 announce, 2 hold, 3 gap.
  // m_left counts down the cycles remaining in the phase.
  int         m_mode;
  int         m_left;
  int         m_tries;
  int         m_cur;
  logic [4:0] m_pend, m_ovr, m_unack, m_prev;
  bit         armed = 0;

  always @(posedge clk) begin
    logic [4:0] r, g, rq;
    int idx;
    if (reset) begin
      m_mode = 0; m_left = 0; m_tries = 0; m_cur = 0;
      m_pend = 0; m_ovr = 0; m_unack = 0; m_prev = 0;
      armed = 1;
    end else begin
      r = req & ~m_prev;
      m_prev = req;
      g = 0;
      rq = 0;
      case (m_mode)
        0: if (m_pend != 0) begin
          idx = 0;
          for (int i = 0; i < 5; i++) if (m_pend[i]) idx = i;
          g[idx] = 1'b1;
          m_cur = idx; m_tries = 0;
          m_mode = 1; m_left = ANN;
        end
        1, 2: begin
          if (ack) begin
            m_mode = 3; m_left = GAP;
          end else if (m_pend[4] && m_cur != 4) begin
            rq[m_cur] = 1'b1;
            g[4] = 1'b1;
            m_cur = 4; m_tries = 0;
            m_mode = 1; m_left = ANN;
          end else begin
            m_left--;
            if (m_left == 0) begin
              if (m_mode == 1) begin
                m_mode = 2; m_left = HOLD;
              end else if (m_tries < MAXR) begin
                m_tries++;
                m_mode = 1; m_left = ANN;
              end else begin
                m_unack[m_cur] = 1'b1;
                m_mode = 3; m_left = GAP;
              end
            end
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      endcase
      m_ovr  = m_ovr | (r & m_pend & ~g);
      m_pend = (m_pend & ~g) | rq | r;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("siren", 8'(siren), 8'(m_mode == 1));
      chk("code", 8'(alert_code),
          (m_mode == 1 || m_mode == 2) ? 8'(m_cur + 1) : 8'd0);
      chk("busy", 8'(busy), 8'(m_mode != 0));
      chk("pending", 8'(pending), 8'(m_pend));
      chk("overrun", 8'(overrun), 8'(m_ovr));
      chk("unacked", 8'(unacked), 8'(m_unack));
    end
  end

  task automatic nc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic s, input logic [2:0] c,
                            input int budget, input string nm);
    int k;
    k = 0;
    while (!(siren === s && alert_code === c) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!(siren === s && alert_code === c)) begin
      n_bad++;
      $display("FAIL %s: timeout, siren %0b code %0d want %0b/%0d",
               nm, siren, alert_code, s, c);
    end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: timeout, busy %0b want 0", nm, busy);
    end
  endtask

  task automatic pulse_req(input logic [4:0] v);
    req = v;
    nc(1);
    req = '0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    nc(1);
    ack = 1'b0;
  endtask

  initial begin
    int bursts, hi, lo_hold, k;
    logic prev;

    // reset state
    reset = 1'b1;
    nc(3);
    reset = 1'b0;
    chk("rst_siren", 8'(siren), 8'd0);
    chk("rst_code", 8'(alert_code), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_pend", 8'(pending), 8'd0);

    // single rain pulse, ack late in hold
    pulse_req(5'b00001);
    chk("t1_pend", 8'(pending), 8'h01);
    chk("t1_idle_siren", 8'(siren), 8'd0);
    nc(1);
    chk("t1_siren_on", 8'(siren), 8'd1);
    chk("t1_code", 8'(alert_code), 8'd1);
    for (int i = 0; i < ANN - 1; i++) begin
      nc(1);
      chk("t1_siren_hold", 8'(siren), 8'd1);
    end
    nc(1);
    chk("t1_siren_off", 8'(siren), 8'd0);
    chk("t1_hold_code", 8'(alert_code), 8'd1);
    nc(10);
    do_ack();
    chk("t1_gap_code", 8'(alert_code), 8'd0);
    chk("t1_gap_busy", 8'(busy), 8'd1);
    nc(3);
    chk("t1_gap_end_busy", 8'(busy), 8'd1);
    nc(2);
    chk("t1_idle_busy", 8'(busy), 8'd0);

    // water + burglar together
    req = 5'b01010;
    nc(1);
    chk("t2_pend", 8'(pending), 8'h0a);
    nc(1);
    req = '0;
    chk("t2_code_b", 8'(alert_code), 8'd4);
    chk("t2_pend_b", 8'(pending), 8'h02);
    wait_state(1'b0, 3'd4, 20, "t2_hold_b");
    nc(1);
    do_ack();
    wait_state(1'b1, 3'd2, 20, "t2_ann_w");
    wait_state(1'b0, 3'd2, 20, "t2_hold_w");
    nc(1);
    do_ack();
    wait_idle(20, "t2_idle");
    chk("t2_pend_end", 8'(pending), 8'h00);
    chk("t2_ovr", 8'(overrun), 8'h00);

    // shatter never acked
    pulse_req(5'b00100);
    bursts = 0; hi = 0; lo_hold = 0; k = 0; prev = 1'b0;
    while (k < 600) begin
      @(negedge clk);
      k++;
      if (siren && !prev) bursts++;
      if (siren) hi++;
      else if (alert_code == 3'd3) lo_hold++;
      prev = siren;
      if (!busy && bursts > 0) break;
    end
    chk("t3_bursts", 8'(bursts), 8'd4);
    chk("t3_on_cycles", 8'(hi), 8'd32);
    chk("t3_hold_cycles", 8'(lo_hold / 4), 8'd64);
    chk("t3_unacked", 8'(unacked), 8'h04);
    chk("t3_busy", 8'(busy), 8'd0);

    // fire preempts rain in hold
    pulse_req(5'b00001);
    wait_state(1'b1, 3'd1, 10, "t4_ann_r");
    wait_state(1'b0, 3'd1, 20, "t4_hold_r");
    nc(2);
    pulse_req(5'b10000);
    chk("t4_pend_f", 8'(pending), 8'h10);
    nc(1);
    chk("t4_preempt_siren", 8'(siren), 8'd1);
    chk("t4_preempt_code", 8'(alert_code), 8'd5);
    chk("t4_requeue", 8'(pending), 8'h01);
    nc(2);
    do_ack();
    wait_state(1'b1, 3'd1, 20, "t4_reann_r");
    nc(3);
    do_ack();
    wait_idle(20, "t4_idle");

    // fire rises in the cycle burglar is acked
    pulse_req(5'b01000);
    wait_state(1'b1, 3'd4, 10, "t5_ann_b");
    nc(3);
    ack = 1'b1;
    req = 5'b10000;
    nc(1);
    ack = 1'b0;
    req = '0;
    chk("t5_gap_code", 8'(alert_code), 8'd0);
    chk("t5_pend", 8'(pending), 8'h10);
    nc(4);
    chk("t5_idle", 8'(busy), 8'd0);
    nc(1);
    chk("t5_fire", 8'(alert_code), 8'd5);
    chk("t5_no_b", 8'(pending), 8'h00);
    nc(2);
    do_ack();
    wait_idle(20, "t5_idle_end");

    // double water event under fire
    pulse_req(5'b10000);
    wait_state(1'b1, 3'd5, 10, "t6_fire");
    pulse_req(5'b00010);
    nc(1);
    pulse_req(5'b00010);
    chk("t6_ovr", 8'(overrun), 8'h02);
    chk("t6_pend", 8'(pending), 8'h02);
    do_ack();
    wait_state(1'b1, 3'd2, 20, "t6_water");
    nc(2);
    do_ack();
    wait_idle(20, "t6_idle");
    nc(10);
    chk("t6_once", 8'(busy), 8'd0);
    chk("t6_ovr_sticky", 8'(overrun), 8'h02);

    // reset mid-announce
    pulse_req(5'b00001);
    wait_state(1'b1, 3'd1, 10, "t7_ann");
    nc(2);
    reset = 1'b1;
    nc(1);
    chk("t7_siren", 8'(siren), 8'd0);
    chk("t7_code", 8'(alert_code), 8'd0);
    chk("t7_busy", 8'(busy), 8'd0);
    chk("t7_flags", 8'({pending, 3'b000} | 8'(overrun)), 8'd0);
    chk("t7_unack", 8'(unacked), 8'd0);

    // level held through reset counts as a rise
    req = 5'b01000;
    nc(1);
    reset = 1'b0;
    nc(1);
    chk("t8_pend", 8'(pending), 8'h08);
    req = '0;
    wait_state(1'b1, 3'd4, 10, "t8_ann");
    do_ack();
    wait_idle(20, "t8_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not end, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alert_scheduler.md
Name: alert_scheduler

Overview:
Shares the single household siren and annunciator among the alarm sources: fire, burglar, window shatter, water level and rain. It latches alarm events, then grants the siren to one source at a time by fixed priority. Fire always preempts. Each alert is announced, held until a user acknowledge, re-announced on timeout, and retired after a quiet gap. It sits between the sensor-decode blocks and the siren/display drivers in the top-level home controller.

Parameters:
ANN_CYCLES, 8, cycles the siren is driven per announcement (>=1)
HOLD_CYCLES, 64, cycles to wait for ack before re-announcing (>=1)
GAP_CYCLES, 4, quiet cycles between retiring one alert and granting the next (>=1)
MAX_RETRY, 3, re-announcements without ack before the alert is abandoned
CNT_W, 8, width of the internal cycle counter; must hold max(ANN,HOLD,GAP)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req  in  5  level alarm inputs: [4] fire, [3] burglar, [2] shatter, [1] water, [0] rain
ack  in  1  user acknowledge (single-cycle pulse or level)
siren  out  1  siren drive, high during ANNOUNCE only
alert_code  out  3  0 none, 1 rain, 2 water, 3 shatter, 4 burglar, 5 fire
busy  out  1  high in any state except IDLE
pending  out  5  latched, not-yet-served events, same bit map as req
overrun  out  5  sticky: new event on a source whose pending bit was already set
unacked  out  5  sticky: alert abandoned after MAX_RETRY re-announcements

Behaviour:
- All outputs are registered.
- Reset (synchronous) clears everything: state=IDLE; siren, alert_code, busy, pending, overrun, unacked, req_q, counter, retry count and current index all = 0.
- Edge detect: req_q <= req; rise = req & ~req_q.
  - A level already high when reset releases counts as a rise on the first cycle after reset.
  - pending[i] is set on rise[i].
  - If a pending bit is cleared by a grant in the same cycle it rises, the set wins.
  - overrun[i] is set on rise[i] while pending[i]=1 and that bit is not being granted that cycle.
- Priority: fire > burglar > shatter > water > rain; the highest set pending bit is granted.
- State IDLE:
  - Siren=0, alert_code=0.
  - If pending!=0, grant the highest bit: cur<=idx, clear pending[idx], retry<=0, counter<=0, go to ANNOUNCE.
  - Latency: a rise sampled at edge k gives pending visible after edge k, and siren=1 with a valid alert_code after edge k+1.
- State ANNOUNCE:
  - Siren=1, alert_code=code(cur).
  - Lasts exactly ANN_CYCLES cycles, then go to HOLD with counter<=0.
- State HOLD:
  - Siren=0, alert_code stays code(cur).
  - Timeout at HOLD_CYCLES: if retry<MAX_RETRY, retry++ and return to ANNOUNCE. Otherwise set unacked[cur] and go to GAP.
- ack in ANNOUNCE or HOLD: go to GAP next cycle, retiring cur. ack in IDLE or GAP is ignored.
- Fire preemption:
  - Applies in ANNOUNCE or HOLD when pending[4]=1, cur!=fire and ack=0.
  - The current source is re-queued by setting pending[cur].
  - cur<=fire, clear pending[4], retry<=0, counter<=0, go to ANNOUNCE.
  - ack in the same cycle wins: cur is retired and fire is served after the gap.
- State GAP:
  - Siren=0, alert_code=0, busy=1.
  - After GAP_CYCLES go to IDLE.
  - A new grant happens in IDLE, so there is at least one IDLE cycle with busy=0 between alerts.
- Counter and timing:
  - The counter resets on every state entry and never wraps for legal parameters.
  - Total announcements per alert without ack = 1+MAX_RETRY.
- Reset asserted mid-operation aborts immediately. The siren drops the cycle after reset is sampled, and all pending events are lost.
- Simultaneous rises on several sources are all latched and served one per alert cycle in priority order.

Test Plan:
- Reset, then a 1-cycle req[0] pulse sampled at edge 10 -> pending=5'b00001 after edge 10; siren=1 and alert_code=1 for exactly 8 cycles (after edges 11..18); ack at edge 30 -> GAP for 4 cycles with code 0; busy=0 after edge 35.
- req[1] and req[3] rise together, ack issued 2 cycles into each HOLD -> burglar (code 4) served first, then water (code 2); pending returns to 0; overrun=0.
- req[2] with no ack ever -> siren asserted in exactly 4 bursts of 8 cycles separated by 64-cycle holds; then unacked[2]=1, GAP, IDLE, busy=0.
- Rain in HOLD, fire rises -> next state ANNOUNCE with code 5, pending[0]=1; after fire is acked and the gap ends, rain is re-announced with code 1 and retry restarted.
- Fire rise in the same cycle as ack of a burglar alert -> burglar retired (not re-queued); GAP 4 cycles; then fire announced; pending[3]=0.
- req[1] pulsed twice while a fire alert holds the siren -> overrun[1]=1 and it stays 1 until reset; water served once; reset asserted mid-ANNOUNCE -> siren=0 and all outputs 0 on the next cycle.
